// File: rtl/vend_pkg.sv
// Shared types and constants for the vending front end and the vending FSM it feeds.
package vend_pkg;

    localparam int CREDIT_W       = 3;
    localparam int MAX_CREDIT_DEF = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_M = 2'd1,
        PULSE_A = 2'd2,
        GAP     = 2'd3
    } issue_state_t;

endpackage

// File: rtl/vend_debounce.sv
// Two-flop synchronizer plus stable-count debouncer; flags the edge where the
// debounced level is about to go 0->1 so the caller can latch it on that same edge.
module vend_debounce
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    // The count that would reach DEBOUNCE_CYCLES is folded into an accept, so the
    // counter never actually holds that value.
    always_comb begin
        accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
        level_d = accept ? sync2_q : level_q;
        if ((sync2_q == level_q) || accept) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        rise_o = accept & sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/vend_front_end.sv
// Front end for the coin/select vending FSM: debounced presses become one-cycle
// m/a pulses spaced by a credit-settling gap, with vend checking and error flags.
module vend_front_end
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_CREDIT      = MAX_CREDIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_raw,
    input  logic                sel_raw,
    input  logic [CREDIT_W-1:0] credit,
    input  logic                dispense,
    output logic                m,
    output logic                a,
    output logic                coin_reject,
    output logic                no_credit,
    output logic                fault,
    output logic                overrun,
    output logic [7:0]          vend_count
);

    localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDIT);

    logic         coin_rise;
    logic         sel_rise;
    issue_state_t state_q, state_d;
    logic         m_q, m_d;
    logic         a_q, a_d;
    logic         rej_q, rej_d;
    logic         nc_q, nc_d;
    logic         coin_pend_q, coin_pend_d;
    logic         sel_pend_q, sel_pend_d;
    logic         coin_clr;
    logic         sel_clr;
    logic         fault_q, fault_d;
    logic         overrun_q, overrun_d;
    logic [7:0]   vend_q, vend_d;

    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin_db (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (coin_raw),
        .rise_o (coin_rise)
    );

    vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (sel_raw),
        .rise_o (sel_rise)
    );

    // Coin has priority; a waiting select is picked up after the gap with settled credit.
    always_comb begin
        state_d  = state_q;
        m_d      = 1'b0;
        a_d      = 1'b0;
        rej_d    = 1'b0;
        nc_d     = 1'b0;
        coin_clr = 1'b0;
        sel_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_pend_q) begin
                    coin_clr = 1'b1;
                    if (credit < MAX_C) begin
                        m_d     = 1'b1;
                        state_d = PULSE_M;
                    end else begin
                        rej_d   = 1'b1;
                        state_d = GAP;
                    end
                end else if (sel_pend_q) begin
                    sel_clr = 1'b1;
                    if (credit != '0) begin
                        a_d     = 1'b1;
                        state_d = PULSE_A;
                    end else begin
                        nc_d    = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            PULSE_M: state_d = GAP;
            PULSE_A: state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new rise wins over a same-edge clear so no press is ever lost.
    always_comb begin
        coin_pend_d = coin_rise | (coin_pend_q & ~coin_clr);
        sel_pend_d  = sel_rise | (sel_pend_q & ~sel_clr);
        overrun_d   = overrun_q | (coin_rise & coin_pend_q) | (sel_rise & sel_pend_q);
        fault_d     = fault_q | ((state_q == PULSE_A) & ~dispense);
        vend_d      = vend_q;
        if ((state_q == PULSE_A) && dispense && (vend_q != 8'hFF)) begin
            vend_d = vend_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            m_q         <= 1'b0;
            a_q         <= 1'b0;
            rej_q       <= 1'b0;
            nc_q        <= 1'b0;
            coin_pend_q <= 1'b0;
            sel_pend_q  <= 1'b0;
            fault_q     <= 1'b0;
            overrun_q   <= 1'b0;
            vend_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            a_q         <= a_d;
            rej_q       <= rej_d;
            nc_q        <= nc_d;
            coin_pend_q <= coin_pend_d;
            sel_pend_q  <= sel_pend_d;
            fault_q     <= fault_d;
            overrun_q   <= overrun_d;
            vend_q      <= vend_d;
        end
    end

    assign m           = m_q;
    assign a           = a_q;
    assign coin_reject = rej_q;
    assign no_credit   = nc_q;
    assign fault       = fault_q;
    assign overrun     = overrun_q;
    assign vend_count  = vend_q;

endmodule

// File: tb/tb_vend_front_end.sv
// Randomized and directed bench for vend_front_end against a press-level model.
module tb_vend_front_end;

    localparam int D  = 4;
    localparam int MC = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_raw = 1'b0;
    logic       sel_raw = 1'b0;
    logic [2:0] credit = 3'd0;
    logic       disp_en = 1'b1;
    logic       dispense;
    logic       m, a, coin_reject, no_credit, fault, overrun;
    logic [7:0] vend_count;

    int checks = 0;
    int passed = 0;

    // Press-level expectations
    int exp_vend = 0;
    bit exp_fault = 1'b0;

    int cyc = 0;
    int m_hi = 0, a_hi = 0, rej_hi = 0, nc_hi = 0, both_hi = 0, long_hi = 0;
    int last_m_cyc = 0, last_a_cyc = 0;
    logic pm = 1'b0, pa = 1'b0, pr = 1'b0, pn = 1'b0;

    // The bench stands in for the vending FSM: it dispenses on a select unless forced off.
    assign dispense = a & disp_en;

    vend_front_end #(.DEBOUNCE_CYCLES(D), .MAX_CREDIT(MC)) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_raw    (coin_raw),
        .sel_raw     (sel_raw),
        .credit      (credit),
        .dispense    (dispense),
        .m           (m),
        .a           (a),
        .coin_reject (coin_reject),
        .no_credit   (no_credit),
        .fault       (fault),
        .overrun     (overrun),
        .vend_count  (vend_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (m) begin m_hi++; last_m_cyc = cyc; end
        if (a) begin a_hi++; last_a_cyc = cyc; end
        if (coin_reject) rej_hi++;
        if (no_credit) nc_hi++;
        if (m && a) both_hi++;
        if ((m && pm) || (a && pa) || (coin_reject && pr) || (no_credit && pn)) long_hi++;
        pm = m; pa = a; pr = coin_reject; pn = no_credit;
    end

    task automatic press(input bit c, input bit s);
        @(negedge clk);
        coin_raw = c;
        sel_raw  = s;
        repeat (D + 12) @(negedge clk);
        coin_raw = 1'b0;
        sel_raw  = 1'b0;
        repeat (D + 8) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({m, a, coin_reject, no_credit, fault, overrun, vend_count} !== 14'd0)
            $display("FAIL reset_held: got %b required 0",
                     {m, a, coin_reject, no_credit, fault, overrun, vend_count});
        else passed++;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m, a, coin_reject, no_credit, fault, overrun, vend_count} !== 14'd0)
            $display("FAIL reset_release: got %b required 0",
                     {m, a, coin_reject, no_credit, fault, overrun, vend_count});
        else passed++;
    endtask

    task automatic test_clean_coin;
        int first = 0;
        int hi = 0;
        int ahi = 0;
        credit = 3'd0;
        @(negedge clk);
        coin_raw = 1'b1;
        for (int k = 1; k <= D + 8; k++) begin
            @(negedge clk);
            if (m) begin hi++; if (first == 0) first = k; end
            if (a) ahi++;
        end
        coin_raw = 1'b0;
        repeat (D + 8) @(negedge clk);
        checks++;
        if (first !== D + 3) $display("FAIL coin_latency: got %0d required %0d", first, D + 3);
        else passed++;
        checks++;
        if (hi !== 1) $display("FAIL coin_width: got %0d required 1", hi);
        else passed++;
        checks++;
        if (ahi !== 0) $display("FAIL coin_no_a: got %0d required 0", ahi);
        else passed++;
    endtask

    task automatic test_bounce;
        int m0 = m_hi;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            coin_raw = (k % 2 == 0);
            @(negedge clk);
        end
        coin_raw = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (m_hi - m0 !== 0) $display("FAIL bounce_m: got %0d required 0", m_hi - m0);
        else passed++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL bounce_overrun: got %b required 0", overrun);
        else passed++;
    endtask

    task automatic test_refusals;
        int m0 = m_hi, r0 = rej_hi, a0 = a_hi, n0 = nc_hi;
        credit = 3'd5;
        press(1'b1, 1'b0);
        checks++;
        if (rej_hi - r0 !== 1) $display("FAIL reject_pulse: got %0d required 1", rej_hi - r0);
        else passed++;
        checks++;
        if (m_hi - m0 !== 0) $display("FAIL reject_no_m: got %0d required 0", m_hi - m0);
        else passed++;
        credit = 3'd0;
        press(1'b0, 1'b1);
        checks++;
        if (nc_hi - n0 !== 1) $display("FAIL no_credit_pulse: got %0d required 1", nc_hi - n0);
        else passed++;
        checks++;
        if (a_hi - a0 !== 0) $display("FAIL no_credit_no_a: got %0d required 0", a_hi - a0);
        else passed++;
    endtask

    task automatic test_both;
        int m0 = m_hi, a0 = a_hi;
        credit  = 3'd1;
        disp_en = 1'b1;
        exp_vend = (exp_vend < 255) ? exp_vend + 1 : 255;
        press(1'b1, 1'b1);
        checks++;
        if ((m_hi - m0 !== 1) || (a_hi - a0 !== 1))
            $display("FAIL both_counts: got m=%0d a=%0d required 1 and 1", m_hi - m0, a_hi - a0);
        else passed++;
        checks++;
        if (last_a_cyc - last_m_cyc !== 3)
            $display("FAIL both_spacing: got %0d required 3", last_a_cyc - last_m_cyc);
        else passed++;
        checks++;
        if (vend_count !== 8'(exp_vend))
            $display("FAIL both_vend: got %0d required %0d", vend_count, exp_vend);
        else passed++;
    endtask

    task automatic test_fault;
        credit  = 3'd2;
        disp_en = 1'b0;
        exp_fault = 1'b1;
        press(1'b0, 1'b1);
        checks++;
        if (fault !== exp_fault) $display("FAIL fault_set: got %b required %b", fault, exp_fault);
        else passed++;
        checks++;
        if (vend_count !== 8'(exp_vend))
            $display("FAIL fault_vend: got %0d required %0d", vend_count, exp_vend);
        else passed++;
        disp_en = 1'b1;
        exp_vend = (exp_vend < 255) ? exp_vend + 1 : 255;
        press(1'b0, 1'b1);
        checks++;
        if (fault !== 1'b1) $display("FAIL fault_sticky: got %b required 1", fault);
        else passed++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 20; t++) begin
            int kind = $urandom_range(0, 2);
            int cr   = $urandom_range(0, 7);
            bit de   = ($urandom_range(0, 3) != 0);
            bit c    = (kind != 1);
            bit s    = (kind != 0);
            int em = 0, ea = 0, er = 0, en = 0;
            int m0 = m_hi, a0 = a_hi, r0 = rej_hi, n0 = nc_hi;
            if (c) begin
                if (cr < MC) em = 1; else er = 1;
            end
            if (s) begin
                if (cr != 0) begin
                    ea = 1;
                    if (de) exp_vend = (exp_vend < 255) ? exp_vend + 1 : 255;
                    else exp_fault = 1'b1;
                end else en = 1;
            end
            credit  = 3'(cr);
            disp_en = de;
            press(c, s);
            checks++;
            if ((m_hi - m0 !== em) || (rej_hi - r0 !== er))
                $display("FAIL rand_coin[%0d]: got m=%0d rej=%0d required m=%0d rej=%0d",
                         t, m_hi - m0, rej_hi - r0, em, er);
            else passed++;
            checks++;
            if ((a_hi - a0 !== ea) || (nc_hi - n0 !== en))
                $display("FAIL rand_sel[%0d]: got a=%0d nc=%0d required a=%0d nc=%0d",
                         t, a_hi - a0, nc_hi - n0, ea, en);
            else passed++;
            checks++;
            if ((vend_count !== 8'(exp_vend)) || (fault !== exp_fault))
                $display("FAIL rand_state[%0d]: got vend=%0d fault=%b required vend=%0d fault=%b",
                         t, vend_count, fault, exp_vend, exp_fault);
            else passed++;
        end
        checks++;
        if ((both_hi !== 0) || (long_hi !== 0))
            $display("FAIL pulse_shape: got both=%0d long=%0d required 0 and 0", both_hi, long_hi);
        else passed++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL rand_overrun: got %b required 0", overrun);
        else passed++;
    endtask

    task automatic test_saturate;
        credit  = 3'd3;
        disp_en = 1'b1;
        for (int i = 0; i < 260; i++) begin
            exp_vend = (exp_vend < 255) ? exp_vend + 1 : 255;
            press(1'b0, 1'b1);
        end
        checks++;
        if (vend_count !== 8'(exp_vend))
            $display("FAIL sat_model: got %0d required %0d", vend_count, exp_vend);
        else passed++;
        checks++;
        if (vend_count !== 8'd255) $display("FAIL sat_value: got %0d required 255", vend_count);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        int first = 0;
        int hi = 0;
        credit = 3'd0;
        @(negedge clk);
        coin_raw = 1'b1;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (m) seen = 1;
        end
        checks++;
        if (seen !== 1) $display("FAIL rst_mid_wait: got no m within 20 cycles, required one");
        else passed++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({m, a, coin_reject, no_credit, fault, overrun, vend_count} !== 14'd0)
            $display("FAIL rst_mid_clear: got %b required 0",
                     {m, a, coin_reject, no_credit, fault, overrun, vend_count});
        else passed++;
        exp_vend = 0;
        exp_fault = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= D + 8; k++) begin
            @(negedge clk);
            if (m) begin hi++; if (first == 0) first = k; end
        end
        checks++;
        if ((first !== D + 3) || (hi !== 1))
            $display("FAIL rst_mid_repress: got at=%0d count=%0d required at=%0d count=1",
                     first, hi, D + 3);
        else passed++;
        coin_raw = 1'b0;
        repeat (D + 8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_coin();
        test_bounce();
        test_refusals();
        test_both();
        test_fault();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
